// File: rtl/riscv_pkg.sv
// Shared core constants and the IMEM loader state encoding.
// IMEM_LOADER_CSUM_EN adds the trailing checksum state to the loader.
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned IMEM_DEPTH = 64;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
`ifdef IMEM_LOADER_CSUM_EN
    StCsum,
`endif
    StFlush,
    StDone,
    StErr
  } loader_state_e;

endpackage

// File: rtl/imem_loader_byte_to_word.sv
// Assembles little-endian bytes into 32-bit words; word_valid_o pulses
// combinationally on the cycle the fourth byte of a word is offered.
module imem_loader_byte_to_word (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clear_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_valid_i) begin
      cnt_d = cnt_q + 2'd1;
      unique case (cnt_q)
        2'd0:    shift_d[7:0]   = byte_i;
        2'd1:    shift_d[15:8]  = byte_i;
        2'd2:    shift_d[23:16] = byte_i;
        default: shift_d        = '0;
      endcase
    end
  end

  assign word_valid_o = byte_valid_i && !clear_i && (cnt_q == 2'd3);
  assign word_o       = {byte_i, shift_q};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed little-endian program image into IMEM, holding the CPU
// in reset until done. Define IMEM_LOADER_CSUM_EN to require a trailing checksum byte.
module imem_loader
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned     DEPTH     = IMEM_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            wr_en,
  output logic [XLEN-1:0] wr_addr,
  output logic [XLEN-1:0] wr_data,
  output logic            cpu_reset,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [15:0]     words_loaded
);

  localparam logic [31:0] DepthW = DEPTH;

`ifdef IMEM_LOADER_CSUM_EN
  localparam loader_state_e StAfterData = StCsum;
`else
  localparam loader_state_e StAfterData = StFlush;
`endif

  loader_state_e   state_q, state_d;
  logic            len_hi_q, len_hi_d;
  logic [15:0]     count_q, count_d;
  logic [15:0]     idx_q, idx_d;
  logic            wr_en_q, wr_en_d;
  logic [XLEN-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  logic        start_load;
  logic        data_byte;
  logic        word_valid;
  logic [31:0] word;
  logic [15:0] len_word;

  // start is honoured only outside an active load.
  assign start_load = start && (state_q == StIdle || state_q == StDone || state_q == StErr);
  assign data_byte  = in_valid && (state_q == StData);
  assign len_word   = {in_data, count_q[7:0]};

  imem_loader_byte_to_word u_b2w (
    .clk_i        (clk),
    .rst_i        (reset),
    .clear_i      (start_load),
    .byte_valid_i (data_byte),
    .byte_i       (in_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d   = state_q;
    len_hi_d  = len_hi_q;
    count_d   = count_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d    = csum_q;
`endif
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d  = StLen;
          len_hi_d = 1'b0;
          count_d  = '0;
          idx_d    = '0;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d   = '0;
`endif
        end
      end
      StLen: begin
        if (in_valid) begin
          if (!len_hi_q) begin
            count_d[7:0] = in_data;
            len_hi_d     = 1'b1;
          end else begin
            count_d  = len_word;
            len_hi_d = 1'b0;
            if (len_word == 16'd0) begin
              state_d = StAfterData;
            end else if ({16'h0, len_word} > DepthW) begin
              state_d = StErr;
            end else begin
              state_d = StData;
            end
          end
        end
      end
      StData: begin
        if (in_valid) begin
`ifdef IMEM_LOADER_CSUM_EN
          csum_d = csum_q + in_data;
`endif
          if (word_valid) begin
            wr_en_d   = 1'b1;
            wr_data_d = word;
            wr_addr_d = BASE_ADDR + {14'h0, idx_q, 2'b00};
            idx_d     = idx_q + 16'd1;
            if (idx_d == count_q) begin
              state_d = StAfterData;
            end
          end
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      StCsum: begin
        if (in_valid) begin
          state_d = (in_data == csum_q) ? StFlush : StErr;
        end
      end
`endif
      StFlush: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    cpu_reset = 1'b1;
    unique case (state_q)
      StLen, StData: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`ifdef IMEM_LOADER_CSUM_EN
      StCsum: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      StFlush: busy = 1'b1;
      StDone: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
      end
      StErr:   error = 1'b1;
      default: ;
    endcase
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign words_loaded = idx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      len_hi_q  <= 1'b0;
      count_q   <= '0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= BASE_ADDR;
      wr_data_q <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      len_hi_q  <= len_hi_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

endmodule
